axi4_slave_mem: RTL and testbench

Single-port AXI4 slave memory model with independent write and read burst engines. It sits directly downstream of the AXI4 master stage and terminates its AW/W/B and AR/R channels against an internal word-addressed RAM. It is used both as the bench responder and as the on-chip scratch target. Bursts are FIXED or INCR at full bus width; errors are reported through BRESP and RRESP.

---
 rtl/axi4_slave_mem_if.sv | 58 +++++
 rtl/axi4_slave_mem.sv | 215 +++++++++++++++++++++
 tb/tb_axi4_slave_mem.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_slave_mem_if.sv
// AXI4 channel bundle between a master and the scratch memory slave.
// Carries AW/W/B and AR/R; clk and rst stay outside the bundle.
interface axi4_slave_mem_if #(
    parameter int data_wid = 64,
    parameter int adr_wid  = 32,
    parameter int id_wid   = 8,
    parameter int len_wid  = 8
) ();
    localparam int strb_wid = data_wid / 8;

    logic [id_wid-1:0]   AWID;
    logic [adr_wid-1:0]  AWADDR;
    logic [len_wid-1:0]  AWLEN;
    logic [2:0]          AWSIZE;
    logic [1:0]          AWBURST;
    logic                AWVALID;
    logic                AWREADY;
    logic [data_wid-1:0] WDATA;
    logic [strb_wid-1:0] WSTRB;
    logic                WLAST;
    logic                WVALID;
    logic                WREADY;
    logic [id_wid-1:0]   BID;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;
    logic [id_wid-1:0]   ARID;
    logic [adr_wid-1:0]  ARADDR;
    logic [len_wid-1:0]  ARLEN;
    logic [2:0]          ARSIZE;
    logic [1:0]          ARBURST;
    logic                ARVALID;
    logic                ARREADY;
    logic [id_wid-1:0]   RID;
    logic [data_wid-1:0] RDATA;
    logic [1:0]          RRESP;
    logic                RLAST;
    logic                RVALID;
    logic                RREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output WDATA, WSTRB, WLAST, WVALID, BREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output RREADY,
        input  AWREADY, WREADY, BID, BRESP, BVALID,
        input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  WDATA, WSTRB, WLAST, WVALID, BREADY,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  RREADY,
        output AWREADY, WREADY, BID, BRESP, BVALID,
        output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );
endinterface

// File: rtl/axi4_slave_mem.sv
// AXI4 slave backed by a word-addressed RAM.
// Independent write and read burst engines, FIXED/INCR, full width.
module axi4_slave_mem #(
    parameter int data_wid  = 64,
    parameter int adr_wid   = 32,
    parameter int id_wid    = 8,
    parameter int len_wid   = 8,
    parameter int mem_depth = 256
) (
    input logic             clk,
    input logic             rst,
    axi4_slave_mem_if.slave bus
);
    localparam int strb_wid = data_wid / 8;
    localparam int lsb      = $clog2(strb_wid);
    localparam int idx_w    = $clog2(mem_depth);
    localparam logic [2:0] full_size = 3'(lsb);
    localparam logic [1:0] burst_fixed = 2'b00;
    localparam logic [1:0] okay   = 2'b00;
    localparam logic [1:0] slverr = 2'b10;
    localparam logic [1:0] decerr = 2'b11;
    localparam logic [adr_wid-1:0] amask = {adr_wid{1'b1}} << lsb;
    localparam logic [adr_wid-1:0] step  = adr_wid'(strb_wid);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [data_wid-1:0] mem [mem_depth];

    function automatic logic in_range(input logic [adr_wid-1:0] a);
        return (a >> (idx_w + lsb)) == '0;
    endfunction

    // Response codes are ordered so the numerically larger one is worse.
    function automatic logic [1:0] worst(input logic [1:0] a,
                                         input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    w_state_t            w_state, w_next;
    logic [id_wid-1:0]   w_id;
    logic [len_wid-1:0]  w_len;
    logic [1:0]          w_burst;
    logic [adr_wid-1:0]  w_addr;
    logic [len_wid:0]    w_cnt;
    logic [1:0]          w_err, b_resp, w_resp_n;
    logic                w_bad, aw_bad, aw_hs, w_hs, w_proto, w_we;
    logic [idx_w-1:0]    w_idx;

    assign aw_hs    = bus.AWVALID && bus.AWREADY;
    assign w_hs     = bus.WVALID && bus.WREADY;
    assign aw_bad   = (bus.AWSIZE != full_size) || bus.AWBURST[1];
    assign w_proto  = bus.WLAST ? (w_cnt != {1'b0, w_len})
                                : (w_cnt >  {1'b0, w_len});
    assign w_resp_n = worst(worst(w_err, w_proto ? slverr : okay),
                            in_range(w_addr) ? okay : decerr);
    assign w_we     = w_hs && !w_bad && in_range(w_addr);
    assign w_idx    = w_addr[idx_w+lsb-1:lsb];
    assign bus.BID   = w_id;
    assign bus.BRESP = b_resp;

    // Write FSM state register.
    always_ff @(posedge clk) begin
        if (rst) w_state <= W_IDLE;
        else     w_state <= w_next;
    end

    // Write FSM next state and channel handshakes.
    always_comb begin
        w_next      = w_state;
        bus.AWREADY = 1'b0;
        bus.WREADY  = 1'b0;
        bus.BVALID  = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                bus.AWREADY = !rst;
                if (aw_hs) w_next = W_DATA;
            end
            W_DATA: begin
                bus.WREADY = !rst;
                if (w_hs && bus.WLAST) w_next = W_RESP;
            end
            W_RESP: begin
                bus.BVALID = 1'b1;
                if (bus.BREADY) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    // Write burst context: address walk, beat count, sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_id    <= '0;
            w_len   <= '0;
            w_burst <= '0;
            w_addr  <= '0;
            w_cnt   <= '0;
            w_err   <= okay;
            w_bad   <= 1'b0;
            b_resp  <= okay;
        end else begin
            if (aw_hs) begin
                w_id    <= bus.AWID;
                w_len   <= bus.AWLEN;
                w_burst <= bus.AWBURST;
                w_addr  <= bus.AWADDR & amask;
                w_cnt   <= '0;
                w_bad   <= aw_bad;
                w_err   <= aw_bad ? slverr : okay;
            end
            if (w_hs) begin
                w_err <= w_resp_n;
                if (~&w_cnt) w_cnt <= w_cnt + 1'b1;
                if (w_burst != burst_fixed) w_addr <= w_addr + step;
                if (bus.WLAST) b_resp <= w_resp_n;
            end
        end
    end

    // Byte-strobed RAM write; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int b = 0; b < strb_wid; b++) begin
                if (bus.WSTRB[b])
                    mem[w_idx][b*8 +: 8] <= bus.WDATA[b*8 +: 8];
            end
        end
    end

    r_state_t            r_state, r_next;
    logic [len_wid-1:0]  r_len, r_cnt;
    logic [1:0]          r_burst, r_src_burst;
    logic [adr_wid-1:0]  r_addr, r_src;
    logic [1:0]          r_err, r_base, r_resp_n, r_resp;
    logic                r_bad, ar_bad, ar_hs, r_hs, r_load;
    logic                r_src_bad, r_zero, r_last;
    logic [id_wid-1:0]   r_id;
    logic [data_wid-1:0] r_data;

    assign ar_hs       = bus.ARVALID && bus.ARREADY;
    assign r_hs        = bus.RVALID && bus.RREADY;
    assign ar_bad      = (bus.ARSIZE != full_size) || bus.ARBURST[1];
    assign r_src       = ar_hs ? (bus.ARADDR & amask) : r_addr;
    assign r_src_bad   = ar_hs ? ar_bad : r_bad;
    assign r_src_burst = ar_hs ? bus.ARBURST : r_burst;
    assign r_base      = ar_hs ? (ar_bad ? slverr : okay) : r_err;
    assign r_resp_n    = worst(r_base, in_range(r_src) ? okay : decerr);
    assign r_zero      = r_src_bad || !in_range(r_src);
    assign r_load      = ar_hs || (r_hs && !bus.RLAST);
    assign bus.RID     = r_id;
    assign bus.RDATA   = r_data;
    assign bus.RRESP   = r_resp;
    assign bus.RLAST   = r_last;

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= R_IDLE;
        else     r_state <= r_next;
    end

    // Read FSM next state and channel handshakes.
    always_comb begin
        r_next      = r_state;
        bus.ARREADY = 1'b0;
        bus.RVALID  = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                bus.ARREADY = !rst;
                if (ar_hs) r_next = R_DATA;
            end
            R_DATA: begin
                bus.RVALID = 1'b1;
                if (r_hs && bus.RLAST) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Read beat pipeline: the next beat is fetched on the handshake
    // that retires the current one, so R outputs hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_id    <= '0;
            r_len   <= '0;
            r_burst <= '0;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_err   <= okay;
            r_bad   <= 1'b0;
            r_data  <= '0;
            r_resp  <= okay;
            r_last  <= 1'b0;
        end else begin
            if (ar_hs) begin
                r_id    <= bus.ARID;
                r_len   <= bus.ARLEN;
                r_burst <= bus.ARBURST;
                r_bad   <= ar_bad;
                r_last  <= (bus.ARLEN == '0);
                r_cnt   <= len_wid'(1);
            end else if (r_hs && !bus.RLAST) begin
                r_last <= (r_cnt == r_len);
                r_cnt  <= r_cnt + 1'b1;
            end
            if (r_load) begin
                r_data <= r_zero ? '0 : mem[r_src[idx_w+lsb-1:lsb]];
                r_resp <= r_resp_n;
                r_err  <= r_resp_n;
                r_addr <= (r_src_burst != burst_fixed) ? r_src + step
                                                       : r_src;
            end
        end
    end
endmodule

// File: tb/tb_axi4_slave_mem.sv
// Bench for axi4_slave_mem: directed vectors, corner sequences
// and randomized bursts against a byte-level memory model.
module tb_axi4_slave_mem;
    localparam int TOP = 256 * 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi4_slave_mem_if bus ();
    axi4_slave_mem dut (.clk(clk), .rst(rst), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] mem_m [256];
    logic [63:0] wr_data [$];
    logic [7:0]  wr_strb [$];
    logic [63:0] rd_data [$];
    logic [1:0]  rd_resp [$];
    logic        rd_last [$];
    logic [7:0]  rd_id   [$];
    logic [63:0] ex_data [$];
    logic [1:0]  ex_resp [$];

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          nbeats;
        int          last_at;
        logic [1:0]  exp_b;
        logic [1:0]  exp_r;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] worst(input logic [1:0] a,
                                         input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Reference write: apply beats to the model, return expected BRESP.
    task automatic m_write(input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int nbeats, input int last_at,
                           output logic [1:0] resp);
        logic [31:0] a;
        logic        bad;
        logic        last;
        a    = addr & ~32'h7;
        bad  = (size != 3'd3) || (burst >= 2'd2);
        resp = bad ? 2'b10 : 2'b00;
        for (int i = 0; i < nbeats; i++) begin
            last = (i == last_at);
            if (a >= TOP) resp = worst(resp, 2'b11);
            else if (!bad)
                for (int b = 0; b < 8; b++)
                    if (wr_strb[i][b])
                        mem_m[a[10:3]][b*8 +: 8] = wr_data[i][b*8 +: 8];
            if (last && i != int'(len)) resp = worst(resp, 2'b10);
            if (!last && i > int'(len)) resp = worst(resp, 2'b10);
            if (burst == 2'b01) a = a + 32'd8;
        end
    endtask

    // Reference read: expected data and response per beat.
    task automatic m_read(input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] a;
        logic        bad;
        logic [1:0]  e;
        ex_data.delete();
        ex_resp.delete();
        a   = addr & ~32'h7;
        bad = (size != 3'd3) || (burst >= 2'd2);
        e   = bad ? 2'b10 : 2'b00;
        for (int i = 0; i <= int'(len); i++) begin
            if (a >= TOP) e = worst(e, 2'b11);
            ex_data.push_back((bad || a >= TOP) ? 64'd0 : mem_m[a[10:3]]);
            ex_resp.push_back(e);
            if (burst == 2'b01) a = a + 32'd8;
        end
    endtask

    task automatic axi_write(input logic [7:0] id, input logic [31:0] addr,
                             input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input int nbeats,
                             input int last_at, output logic [1:0] resp,
                             output logic [7:0] bid);
        int t;
        logic [10:0] snap;
        bus.AWID = id;
        bus.AWADDR = addr;
        bus.AWLEN = len;
        bus.AWSIZE = size;
        bus.AWBURST = burst;
        bus.AWVALID = 1'b1;
        t = 0;
        while (!bus.AWREADY && t < 200) begin
            @(posedge clk); #1; t++;
        end
        check("aw_ready", 64'(bus.AWREADY), 64'd1);
        @(posedge clk); #1;
        bus.AWVALID = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            bus.WDATA = wr_data[i];
            bus.WSTRB = wr_strb[i];
            bus.WLAST = (i == last_at);
            bus.WVALID = 1'b1;
            check("w_ready", 64'(bus.WREADY), 64'd1);
            t = 0;
            while (!bus.WREADY && t < 200) begin
                @(posedge clk); #1; t++;
            end
            @(posedge clk); #1;
        end
        bus.WVALID = 1'b0;
        bus.WLAST = 1'b0;
        check("b_valid_lat", 64'(bus.BVALID), 64'd1);
        snap = {bus.BVALID, bus.BID, bus.BRESP};
        @(posedge clk); #1;
        check("b_hold", 64'({bus.BVALID, bus.BID, bus.BRESP}), 64'(snap));
        bus.BREADY = 1'b1;
        t = 0;
        while (!bus.BVALID && t < 200) begin
            @(posedge clk); #1; t++;
        end
        resp = bus.BRESP;
        bid = bus.BID;
        @(posedge clk); #1;
        bus.BREADY = 1'b0;
        check("aw_ready_after_b", 64'(bus.AWREADY), 64'd1);
    endtask

    // mode 0: RREADY high, 1: toggle 1,0,1,0..., 2: random
    task automatic axi_read(input logic [7:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input int mode);
        int t;
        logic done, tog, stall;
        logic [63:0] sd;
        logic [11:0] sc;
        rd_data.delete();
        rd_resp.delete();
        rd_last.delete();
        rd_id.delete();
        bus.ARID = id;
        bus.ARADDR = addr;
        bus.ARLEN = len;
        bus.ARSIZE = size;
        bus.ARBURST = burst;
        bus.ARVALID = 1'b1;
        t = 0;
        while (!bus.ARREADY && t < 200) begin
            @(posedge clk); #1; t++;
        end
        check("ar_ready", 64'(bus.ARREADY), 64'd1);
        @(posedge clk); #1;
        bus.ARVALID = 1'b0;
        check("r_first_lat", 64'(bus.RVALID), 64'd1);
        done = 1'b0;
        tog = 1'b1;
        t = 0;
        while (!done && t < 1200) begin
            if (mode == 0) bus.RREADY = 1'b1;
            else if (mode == 1) begin
                bus.RREADY = tog;
                tog = !tog;
            end else bus.RREADY = 1'($urandom_range(0, 1));
            stall = bus.RVALID && !bus.RREADY;
            sd = bus.RDATA;
            sc = {bus.RVALID, bus.RID, bus.RRESP, bus.RLAST};
            if (bus.RVALID && bus.RREADY) begin
                rd_data.push_back(bus.RDATA);
                rd_resp.push_back(bus.RRESP);
                rd_last.push_back(bus.RLAST);
                rd_id.push_back(bus.RID);
                done = bus.RLAST;
            end
            @(posedge clk); #1;
            t++;
            if (stall) begin
                check("r_hold_data", bus.RDATA, sd);
                check("r_hold_ctl",
                      64'({bus.RVALID, bus.RID, bus.RRESP, bus.RLAST}),
                      64'(sc));
            end
        end
        bus.RREADY = 1'b0;
        check("r_done", 64'(done), 64'd1);
        check("ar_ready_after_r", 64'(bus.ARREADY), 64'd1);
    endtask

    task automatic cmp_read(input string name, input logic [7:0] id);
        int n;
        n = rd_data.size();
        check({name, "_beats"}, 64'(n), 64'(ex_data.size()));
        for (int i = 0; i < n && i < ex_data.size(); i++) begin
            check({name, "_data"}, rd_data[i], ex_data[i]);
            check({name, "_resp"}, 64'(rd_resp[i]), 64'(ex_resp[i]));
            check({name, "_last"}, 64'(rd_last[i]),
                  64'(i == ex_data.size() - 1));
            check({name, "_id"}, 64'(rd_id[i]), 64'(id));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [10];
        logic [1:0]  br, eb;
        logic [7:0]  bi, len;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          nb, la;
        logic [63:0] d0, d1;

        tbl[0] = '{32'h100, 8'd0, 3'd3, 2'b01, 1, 0, 2'b00, 2'b00};
        tbl[1] = '{32'h208, 8'd3, 3'd3, 2'b01, 4, 3, 2'b00, 2'b00};
        tbl[2] = '{32'h300, 8'd2, 3'd3, 2'b00, 3, 2, 2'b00, 2'b00};
        tbl[3] = '{32'h7F8, 8'd1, 3'd3, 2'b01, 2, 1, 2'b11, 2'b11};
        tbl[4] = '{32'h400, 8'd3, 3'd3, 2'b01, 3, 2, 2'b10, 2'b00};
        tbl[5] = '{32'h480, 8'd1, 3'd3, 2'b01, 3, 2, 2'b10, 2'b00};
        tbl[6] = '{32'h500, 8'd1, 3'd2, 2'b01, 2, 1, 2'b10, 2'b10};
        tbl[7] = '{32'h580, 8'd0, 3'd3, 2'b11, 1, 0, 2'b10, 2'b10};
        tbl[8] = '{32'h800, 8'd0, 3'd3, 2'b01, 1, 0, 2'b11, 2'b11};
        tbl[9] = '{32'h613, 8'd1, 3'd3, 2'b01, 2, 1, 2'b00, 2'b00};

        bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0;
        bus.AWSIZE = '0; bus.AWBURST = '0; bus.AWVALID = 1'b0;
        bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0;
        bus.WVALID = 1'b0; bus.BREADY = 1'b0;
        bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0;
        bus.ARSIZE = '0; bus.ARBURST = '0; bus.ARVALID = 1'b0;
        bus.RREADY = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ctl", 64'({bus.AWREADY, bus.WREADY, bus.BVALID,
                              bus.ARREADY, bus.RVALID, bus.RLAST,
                              bus.BRESP, bus.RRESP}), 64'd0);
        check("rst_ids", 64'({bus.BID, bus.RID}), 64'd0);
        check("rst_rdata", bus.RDATA, 64'd0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", 64'({bus.AWREADY, bus.ARREADY}), 64'd3);
        @(posedge clk); #1;

        wr_data.delete(); wr_strb.delete();
        for (int i = 0; i < 256; i++) begin
            wr_data.push_back({$urandom, $urandom});
            wr_strb.push_back(8'hFF);
        end
        m_write(32'h0, 8'd255, 3'd3, 2'b01, 256, 255, eb);
        axi_write(8'h00, 32'h0, 8'd255, 3'd3, 2'b01, 256, 255, br, bi);
        check("preload_bresp", 64'(br), 64'd0);

        wr_data = '{64'hDEADBEEF_CAFEF00D};
        wr_strb = '{8'hFF};
        m_write(32'h10, 8'd0, 3'd3, 2'b01, 1, 0, eb);
        axi_write(8'h05, 32'h10, 8'd0, 3'd3, 2'b01, 1, 0, br, bi);
        check("single_bresp", 64'(br), 64'd0);
        check("single_bid", 64'(bi), 64'h05);
        axi_read(8'h05, 32'h10, 8'd0, 3'd3, 2'b01, 0);
        check("single_beats", 64'(rd_data.size()), 64'd1);
        if (rd_data.size() >= 1) begin
            check("single_rdata", rd_data[0], 64'hDEADBEEF_CAFEF00D);
            check("single_rlast", 64'(rd_last[0]), 64'd1);
            check("single_rid", 64'(rd_id[0]), 64'h05);
        end

        wr_data = '{64'hFFFFFFFF_FFFFFFFF};
        wr_strb = '{8'hFF};
        m_write(32'h0, 8'd0, 3'd3, 2'b01, 1, 0, eb);
        axi_write(8'h01, 32'h0, 8'd0, 3'd3, 2'b01, 1, 0, br, bi);
        wr_data = '{64'h0};
        wr_strb = '{8'h0F};
        m_write(32'h0, 8'd0, 3'd3, 2'b01, 1, 0, eb);
        axi_write(8'h01, 32'h0, 8'd0, 3'd3, 2'b01, 1, 0, br, bi);
        axi_read(8'h01, 32'h0, 8'd0, 3'd3, 2'b01, 0);
        check("strobe_beats", 64'(rd_data.size()), 64'd1);
        if (rd_data.size() >= 1)
            check("strobe_rdata", rd_data[0], 64'hFFFFFFFF_00000000);

        wr_data = '{64'd1, 64'd2, 64'd3, 64'd4};
        wr_strb = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        m_write(32'h40, 8'd3, 3'd3, 2'b01, 4, 3, eb);
        axi_write(8'h02, 32'h40, 8'd3, 3'd3, 2'b01, 4, 3, br, bi);
        axi_read(8'h02, 32'h40, 8'd3, 3'd3, 2'b01, 1);
        check("bp_beats", 64'(rd_data.size()), 64'd4);
        for (int i = 0; i < rd_data.size() && i < 4; i++) begin
            check("bp_rdata", rd_data[i], 64'(i + 1));
            check("bp_rlast", 64'(rd_last[i]), 64'(i == 3));
        end

        wr_data = '{64'h1111};
        wr_strb = '{8'hFF};
        m_write(32'h7F0, 8'd0, 3'd3, 2'b01, 1, 0, eb);
        axi_write(8'h03, 32'h7F0, 8'd0, 3'd3, 2'b01, 1, 0, br, bi);
        wr_data = '{64'hAAAA, 64'hBBBB};
        wr_strb = '{8'hFF, 8'hFF};
        m_write(32'h7F8, 8'd1, 3'd3, 2'b01, 2, 1, eb);
        axi_write(8'h03, 32'h7F8, 8'd1, 3'd3, 2'b01, 2, 1, br, bi);
        check("oor_bresp", 64'(br), 64'h3);
        axi_read(8'h03, 32'h7F0, 8'd1, 3'd3, 2'b01, 0);
        check("oor_beats", 64'(rd_data.size()), 64'd2);
        if (rd_data.size() >= 2) begin
            check("oor_keep", rd_data[0], 64'h1111);
            check("oor_last_word", rd_data[1], 64'hAAAA);
        end

        for (int v = 0; v < 10; v++) begin
            wr_data.delete(); wr_strb.delete();
            for (int i = 0; i < tbl[v].nbeats; i++) begin
                wr_data.push_back({$urandom, $urandom});
                wr_strb.push_back(8'hFF);
            end
            m_write(tbl[v].addr, tbl[v].len, tbl[v].size, tbl[v].burst,
                    tbl[v].nbeats, tbl[v].last_at, eb);
            axi_write(8'(v + 16), tbl[v].addr, tbl[v].len, tbl[v].size,
                      tbl[v].burst, tbl[v].nbeats, tbl[v].last_at, br, bi);
            check("tbl_bresp", 64'(br), 64'(tbl[v].exp_b));
            check("tbl_bid", 64'(bi), 64'(v + 16));
            m_read(tbl[v].addr, tbl[v].len, tbl[v].size, tbl[v].burst);
            axi_read(8'(v + 32), tbl[v].addr, tbl[v].len, tbl[v].size,
                     tbl[v].burst, 0);
            cmp_read("tbl", 8'(v + 32));
            if (rd_resp.size() > 0)
                check("tbl_rresp", 64'(rd_resp[rd_resp.size() - 1]),
                      64'(tbl[v].exp_r));
        end

        wr_data.delete(); wr_strb.delete();
        for (int i = 0; i < 8; i++) begin
            wr_data.push_back({$urandom, $urandom});
            wr_strb.push_back(8'hFF);
        end
        m_read(32'h600, 8'd7, 3'd3, 2'b01);
        fork
            axi_write(8'h44, 32'h100, 8'd7, 3'd3, 2'b01, 8, 7, br, bi);
            axi_read(8'h55, 32'h600, 8'd7, 3'd3, 2'b01, 0);
        join
        cmp_read("conc_rd", 8'h55);
        check("conc_bresp", 64'(br), 64'd0);
        m_write(32'h100, 8'd7, 3'd3, 2'b01, 8, 7, eb);
        m_read(32'h100, 8'd7, 3'd3, 2'b01);
        axi_read(8'h56, 32'h100, 8'd7, 3'd3, 2'b01, 2);
        cmp_read("conc_wr", 8'h56);

        d0 = {$urandom, $urandom};
        d1 = {$urandom, $urandom};
        bus.AWID = 8'h01; bus.AWADDR = 32'h700; bus.AWLEN = 8'd3;
        bus.AWSIZE = 3'd3; bus.AWBURST = 2'b01; bus.AWVALID = 1'b1;
        bus.ARID = 8'h02; bus.ARADDR = 32'h0; bus.ARLEN = 8'd7;
        bus.ARSIZE = 3'd3; bus.ARBURST = 2'b01; bus.ARVALID = 1'b1;
        check("mid_idle", 64'({bus.AWREADY, bus.ARREADY}), 64'd3);
        @(posedge clk); #1;
        bus.AWVALID = 1'b0; bus.ARVALID = 1'b0;
        check("mid_busy", 64'({bus.WREADY, bus.RVALID}), 64'd3);
        bus.WDATA = d0; bus.WSTRB = 8'hFF; bus.WLAST = 1'b0;
        bus.WVALID = 1'b1; bus.RREADY = 1'b1;
        @(posedge clk); #1;
        bus.WDATA = d1;
        @(posedge clk); #1;
        bus.WVALID = 1'b0; bus.RREADY = 1'b0;
        check("mid_still_busy", 64'({bus.WREADY, bus.RVALID}), 64'd3);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_ctl", 64'({bus.AWREADY, bus.WREADY, bus.BVALID,
                                  bus.ARREADY, bus.RVALID, bus.RLAST,
                                  bus.BRESP, bus.RRESP}), 64'd0);
        check("mid_rst_ids", 64'({bus.BID, bus.RID}), 64'd0);
        check("mid_rst_rdata", bus.RDATA, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("post_rst_ready", 64'({bus.AWREADY, bus.ARREADY}), 64'd3);
        check("post_rst_valid", 64'({bus.RVALID, bus.BVALID}), 64'd0);
        @(posedge clk); #1;
        check("post_rst_norv", 64'(bus.RVALID), 64'd0);
        mem_m[8'hE0] = d0;
        mem_m[8'hE1] = d1;
        m_read(32'h700, 8'd3, 3'd3, 2'b01);
        axi_read(8'h07, 32'h700, 8'd3, 3'd3, 2'b01, 0);
        cmp_read("rst_keep", 8'h07);

        for (int it = 0; it < 40; it++) begin
            len = 8'($urandom_range(0, 7));
            burst = 2'($urandom_range(0, 1));
            size = ($urandom_range(0, 7) == 0) ? 3'd2 : 3'd3;
            if ($urandom_range(0, 1) == 0) begin
                addr = $urandom_range(0, TOP + 64);
                nb = int'(len) + 1;
                la = int'(len);
                if ($urandom_range(0, 5) == 0) begin
                    la = $urandom_range(0, int'(len) + 1);
                    nb = la + 1;
                end
                wr_data.delete(); wr_strb.delete();
                for (int i = 0; i < nb; i++) begin
                    wr_data.push_back({$urandom, $urandom});
                    wr_strb.push_back(8'($urandom));
                end
                m_write(addr, len, size, burst, nb, la, eb);
                axi_write(8'(it), addr, len, size, burst, nb, la, br, bi);
                check("rnd_bresp", 64'(br), 64'(eb));
                check("rnd_bid", 64'(bi), 64'(it));
            end else begin
                addr = $urandom_range(0, TOP - 8 * (int'(len) + 1));
                m_read(addr, len, size, burst);
                axi_read(8'(it), addr, len, size, burst, 2);
                cmp_read("rnd_rd", 8'(it));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
